mem_responder: RTL and testbench

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/mem_responder.sv | 176 +++++++++++++++++
 tb/tb_mem_responder.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// mem_responder: single-port word memory that answers one request at a time
// from a multicycle core. A request accepted in IDLE waits LATENCY cycles,
// then spends exactly one cycle in RESP, where READY pulses and the access
// takes effect. Optional alignment checking is built when the macro
// MEM_RESPONDER_ALIGN_CHK_EN is defined; without it ERR is tied low and the
// low two address bits are ignored.
module mem_responder #(
    parameter int LATENCY    = 2,
    parameter int DEPTH_LOG2 = 10
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        REQ,
    input  logic        WEN,
    input  logic [3:0]  BE,
    input  logic [31:0] ADDR,
    input  logic [31:0] DI,
    output logic [31:0] DO,
    output logic        READY,
    output logic        BUSY,
    output logic        ERR
);

    localparam int         DEPTH    = 1 << DEPTH_LOG2;
    // Value loaded into the wait counter on acceptance; unused when LATENCY is 0.
    localparam logic [3:0] CNT_LOAD = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t                state;
    state_t                next_state;
    logic [3:0]            cnt;
    logic [3:0]            next_cnt;

    // Fields captured at acceptance; they stay frozen until the next request.
    logic                  wen_q;
    logic [3:0]            be_q;
    logic [DEPTH_LOG2-1:0] idx_q;
    logic [31:0]           di_q;

    // Fields of the access that completes on this edge. With LATENCY=0 the
    // access completes on its own acceptance edge, before anything has been
    // captured, so the live inputs are used while in IDLE.
    logic                  acc_wen;
    logic [3:0]            acc_be;
    logic [DEPTH_LOG2-1:0] acc_idx;
    logic [31:0]           acc_di;
    logic                  acc_mis;

    logic                  accept;
    logic                  enter_resp;

    logic [31:0]           mem [DEPTH];
    logic [31:0]           do_q;

    // Address bits that never select a word; the upper ones alias by design.
    logic                  unused_addr_bits;
    assign unused_addr_bits = ^{ADDR[31:DEPTH_LOG2+2], ADDR[1:0]};

`ifdef MEM_RESPONDER_ALIGN_CHK_EN
    logic                  req_mis;
    logic                  mis_q;

    // A sub-word address is only an error for accesses that need the whole word.
    assign req_mis = (ADDR[1:0] != 2'b00) && (WEN || (BE == 4'hF));
    assign acc_mis = (state == ST_IDLE) ? req_mis : mis_q;
    assign ERR     = (state == ST_RESP) && mis_q;
`else
    assign acc_mis = 1'b0;
    assign ERR     = 1'b0;
`endif

    assign accept     = (state == ST_IDLE) && REQ;
    assign enter_resp = (next_state == ST_RESP) && (state != ST_RESP);

    assign READY = (state == ST_RESP);
    assign BUSY  = (state != ST_IDLE);
    assign DO    = do_q;

    // State and wait counter; reset returns to IDLE and abandons any access.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= ST_IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= next_state;
            cnt   <= next_cnt;
        end
    end

    // Next-state logic: IDLE accepts, WAIT counts down to zero, RESP lasts one cycle.
    always_comb begin
        next_state = state;
        next_cnt   = cnt;
        case (state)
            ST_IDLE: begin
                if (REQ) begin
                    if (LATENCY == 0) begin
                        next_state = ST_RESP;
                        next_cnt   = 4'd0;
                    end else begin
                        next_state = ST_WAIT;
                        next_cnt   = CNT_LOAD;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt == 4'd0) begin
                    next_state = ST_RESP;
                end else begin
                    next_cnt = cnt - 4'd1;
                end
            end
            ST_RESP: begin
                next_state = ST_IDLE;
            end
            default: begin
                next_state = ST_IDLE;
                next_cnt   = 4'd0;
            end
        endcase
    end

    // Select between live inputs and captured fields for the completing access.
    always_comb begin
        if (state == ST_IDLE) begin
            acc_wen = WEN;
            acc_be  = BE;
            acc_idx = ADDR[DEPTH_LOG2+1:2];
            acc_di  = DI;
        end else begin
            acc_wen = wen_q;
            acc_be  = be_q;
            acc_idx = idx_q;
            acc_di  = di_q;
        end
    end

    // Capture the request fields only at acceptance so later input changes are ignored.
    always_ff @(posedge CLK) begin
        if (!RST && accept) begin
            wen_q <= WEN;
            be_q  <= BE;
            idx_q <= ADDR[DEPTH_LOG2+1:2];
            di_q  <= DI;
`ifdef MEM_RESPONDER_ALIGN_CHK_EN
            mis_q <= req_mis;
`endif
        end
    end

    // Byte-lane write on the edge entering RESP; reset on that edge cancels it.
    always_ff @(posedge CLK) begin
        if (!RST && enter_resp && !acc_wen && !acc_mis) begin
            for (int i = 0; i < 4; i++) begin
                if (acc_be[i]) begin
                    mem[acc_idx][8*i +: 8] <= acc_di[8*i +: 8];
                end
            end
        end
    end

    // Read data register: loaded only when a read completes, otherwise held.
    always_ff @(posedge CLK) begin
        if (RST) begin
            do_q <= 32'h0;
        end else if (enter_resp && acc_wen) begin
            do_q <= acc_mis ? 32'h0 : mem[acc_idx];
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: two instances (LATENCY=2 and LATENCY=0) checked every
// cycle against a transaction-level reference model, plus a directed vector
// table and hand-written sequences for holding REQ, reset during an access
// and reset colliding with a request.
module tb_mem_responder;

    localparam int LAT_A      = 2;
    localparam int LAT_B      = 0;
    localparam int DEPTH_LOG2 = 10;
    localparam int DEPTH      = 1 << DEPTH_LOG2;
    localparam int NVEC       = 17;

`ifdef MEM_RESPONDER_ALIGN_CHK_EN
    localparam bit ALIGN_CHK = 1'b1;
`else
    localparam bit ALIGN_CHK = 1'b0;
`endif

    typedef struct {
        logic        wen;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] di;
        logic [31:0] exp_do;
        logic        exp_err;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        req   [2];
    logic        wen   [2];
    logic [3:0]  be    [2];
    logic [31:0] addr  [2];
    logic [31:0] di    [2];
    logic [31:0] dout  [2];
    logic        ready [2];
    logic        busy  [2];
    logic        err   [2];

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state, indexed by instance.
    int          m_edge   [2];
    bit          m_active [2];
    int          m_acc    [2];
    bit          m_wen    [2];
    bit [3:0]    m_be     [2];
    bit [31:0]   m_addr   [2];
    bit [31:0]   m_di     [2];
    bit [31:0]   m_mem    [2][DEPTH];
    bit          m_valid  [2][DEPTH];
    bit [31:0]   e_do     [2];
    bit          e_known  [2];
    bit          e_ready  [2];
    bit          e_busy   [2];
    bit          e_err    [2];

    vec_t tbl [NVEC];

    always #5 clk = ~clk;

    mem_responder #(.LATENCY(LAT_A), .DEPTH_LOG2(DEPTH_LOG2)) u_dut_a (
        .CLK(clk), .RST(rst), .REQ(req[0]), .WEN(wen[0]), .BE(be[0]),
        .ADDR(addr[0]), .DI(di[0]), .DO(dout[0]), .READY(ready[0]),
        .BUSY(busy[0]), .ERR(err[0])
    );

    mem_responder #(.LATENCY(LAT_B), .DEPTH_LOG2(DEPTH_LOG2)) u_dut_b (
        .CLK(clk), .RST(rst), .REQ(req[1]), .WEN(wen[1]), .BE(be[1]),
        .ADDR(addr[1]), .DI(di[1]), .DO(dout[1]), .READY(ready[1]),
        .BUSY(busy[1]), .ERR(err[1])
    );

    function automatic int latOf(int k);
        return (k == 0) ? LAT_A : LAT_B;
    endfunction

    task automatic checkValue(string name, int k, logic [31:0] actual, logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("[TB] FAIL %s (dut%0d): got %h, expected %h", name, k, actual, expected);
        end
    endtask

    // Advance the model by one clock edge using the inputs about to be sampled.
    // An access accepted on edge A takes effect on edge A+L, READY is visible
    // after that edge only, and the block is free again from edge A+L+2.
    task automatic modelEdge(int k);
        int e;
        int lat;
        int idx;
        bit mis;
        lat = latOf(k);
        m_edge[k]++;
        e = m_edge[k];
        if (rst) begin
            m_active[k] = 1'b0;
            e_do[k]     = 32'h0;
            e_known[k]  = 1'b1;
            e_ready[k]  = 1'b0;
            e_busy[k]   = 1'b0;
            e_err[k]    = 1'b0;
            return;
        end
        if (m_active[k] && e == m_acc[k] + lat + 1) begin
            m_active[k] = 1'b0;
        end else if (!m_active[k] && req[k] === 1'b1) begin
            m_active[k] = 1'b1;
            m_acc[k]    = e;
            m_wen[k]    = wen[k];
            m_be[k]     = be[k];
            m_addr[k]   = addr[k];
            m_di[k]     = di[k];
        end
        e_ready[k] = 1'b0;
        e_err[k]   = 1'b0;
        if (m_active[k] && e == m_acc[k] + lat) begin
            mis = ALIGN_CHK && (m_addr[k][1:0] != 2'b00) && (m_wen[k] || m_be[k] == 4'hF);
            idx = int'((m_addr[k] >> 2) % DEPTH);
            if (m_wen[k]) begin
                e_do[k]    = mis ? 32'h0 : m_mem[k][idx];
                e_known[k] = mis || m_valid[k][idx];
            end else if (!mis) begin
                for (int b = 0; b < 4; b++) begin
                    if (m_be[k][b]) m_mem[k][idx][8*b +: 8] = m_di[k][8*b +: 8];
                end
                if (m_be[k] == 4'hF) m_valid[k][idx] = 1'b1;
            end
            e_ready[k] = 1'b1;
            e_err[k]   = mis;
        end
        e_busy[k] = m_active[k];
    endtask

    task automatic checkOutput(int k);
        checkValue("ready", k, 32'(ready[k]), 32'(e_ready[k]));
        checkValue("busy",  k, 32'(busy[k]),  32'(e_busy[k]));
        checkValue("err",   k, 32'(err[k]),   32'(e_err[k]));
        if (e_known[k]) checkValue("do", k, dout[k], e_do[k]);
    endtask

    // One clock: model the coming edge, let the DUTs take it, compare mid-cycle.
    task automatic tick();
        modelEdge(0);
        modelEdge(1);
        @(posedge clk);
        @(negedge clk);
        checkOutput(0);
        checkOutput(1);
    endtask

    // One complete access on instance k; inputs are scrambled after acceptance.
    task automatic applyStimulus(int k, logic w, logic [3:0] b, logic [31:0] a, logic [31:0] d,
                                 output int lat_seen, output logic [31:0] do_seen, output logic err_seen);
        req[k]  = 1'b1;
        wen[k]  = w;
        be[k]   = b;
        addr[k] = a;
        di[k]   = d;
        tick();
        req[k]  = 1'b0;
        wen[k]  = 1'($urandom);
        be[k]   = 4'($urandom);
        addr[k] = $urandom;
        di[k]   = $urandom;
        lat_seen = 0;
        while (ready[k] !== 1'b1 && lat_seen < 20) begin
            tick();
            lat_seen++;
        end
        if (ready[k] !== 1'b1) begin
            n_checks++;
            n_errors++;
            $display("[TB] FAIL ready_timeout (dut%0d): got no READY in %0d cycles, expected one", k, lat_seen);
        end
        do_seen  = dout[k];
        err_seen = err[k];
        tick();
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got time %0t, expected finish before 1000000", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int          lat;
        logic [31:0] dval;
        logic        eflag;
        int          pulses [$];
        int          idle_cnt;
        int          rdy_cnt;

        tbl[0]  = '{1'b0, 4'hF, 32'h10,   32'hDEADBEEF, 32'h0,        1'b0};
        tbl[1]  = '{1'b1, 4'h0, 32'h10,   32'h0,        32'hDEADBEEF, 1'b0};
        tbl[2]  = '{1'b0, 4'h5, 32'h10,   32'h11223344, 32'hDEADBEEF, 1'b0};
        tbl[3]  = '{1'b1, 4'hF, 32'h10,   32'h0,        32'hDE22BE44, 1'b0};
        tbl[4]  = '{1'b0, 4'hF, 32'h14,   32'h12345678, 32'hDE22BE44, 1'b0};
        tbl[5]  = '{1'b1, 4'h0, 32'h14,   32'h0,        32'h12345678, 1'b0};
        tbl[6]  = '{1'b0, 4'hF, 32'h20,   32'hA5A5A5A5, 32'h12345678, 1'b0};
        tbl[7]  = '{1'b1, 4'h0, 32'h1010, 32'h0,        32'hDE22BE44, 1'b0};
        tbl[8]  = '{1'b0, 4'h0, 32'h10,   32'hFFFFFFFF, 32'hDE22BE44, 1'b0};
        tbl[9]  = '{1'b1, 4'h0, 32'h10,   32'h0,        32'hDE22BE44, 1'b0};
        tbl[10] = '{1'b0, 4'hF, 32'h0,    32'h0BADF00D, 32'hDE22BE44, 1'b0};
        tbl[11] = '{1'b1, 4'h0, 32'h0,    32'h0,        32'h0BADF00D, 1'b0};
        tbl[12] = '{1'b1, 4'h0, 32'h13,   32'h0,        ALIGN_CHK ? 32'h0 : 32'hDE22BE44, ALIGN_CHK};
        tbl[13] = '{1'b0, 4'hF, 32'h22,   32'h11111111, ALIGN_CHK ? 32'h0 : 32'hDE22BE44, ALIGN_CHK};
        tbl[14] = '{1'b1, 4'h0, 32'h20,   32'h0,        ALIGN_CHK ? 32'hA5A5A5A5 : 32'h11111111, 1'b0};
        tbl[15] = '{1'b0, 4'h3, 32'h21,   32'h0000BBCC, ALIGN_CHK ? 32'hA5A5A5A5 : 32'h11111111, 1'b0};
        tbl[16] = '{1'b1, 4'h0, 32'h20,   32'h0,        ALIGN_CHK ? 32'hA5A5BBCC : 32'h1111BBCC, 1'b0};

        rst = 1'b1;
        for (int k = 0; k < 2; k++) begin
            req[k] = 1'b0; wen[k] = 1'b1; be[k] = 4'h0; addr[k] = 32'h0; di[k] = 32'h0;
        end
        tick();
        tick();
        checkValue("reset_do",    0, dout[0],         32'h0);
        checkValue("reset_busy",  0, 32'(busy[0]),    32'h0);
        checkValue("reset_ready", 0, 32'(ready[0]),   32'h0);
        rst = 1'b0;
        tick();

        $display("[TB] directed vector table on LATENCY=%0d instance", LAT_A);
        for (int i = 0; i < NVEC; i++) begin
            applyStimulus(0, tbl[i].wen, tbl[i].be, tbl[i].addr, tbl[i].di, lat, dval, eflag);
            checkValue($sformatf("vec%0d_latency", i), 0, 32'(lat),   32'(LAT_A));
            checkValue($sformatf("vec%0d_do", i),      0, dval,       tbl[i].exp_do);
            checkValue($sformatf("vec%0d_err", i),     0, 32'(eflag), 32'(tbl[i].exp_err));
        end

        $display("[TB] zero-latency instance with address aliasing");
        applyStimulus(1, 1'b0, 4'hF, 32'h0, 32'h600DCAFE, lat, dval, eflag);
        checkValue("l0_write_latency", 1, 32'(lat), 32'(LAT_B));
        applyStimulus(1, 1'b1, 4'h0, 32'h1000, 32'h0, lat, dval, eflag);
        checkValue("l0_read_latency", 1, 32'(lat),   32'(LAT_B));
        checkValue("l0_alias_do",     1, dval,       32'h600DCAFE);
        checkValue("l0_alias_err",    1, 32'(eflag), 32'h0);

        $display("[TB] REQ held high continuously");
        req[0] = 1'b1; wen[0] = 1'b1; be[0] = 4'h0; addr[0] = 32'h10; di[0] = 32'h0;
        idle_cnt = 0;
        for (int t = 0; t < 3 * (LAT_A + 2) + 2; t++) begin
            tick();
            if (ready[0] === 1'b1) pulses.push_back(t);
            if (busy[0] === 1'b0) idle_cnt++;
        end
        req[0] = 1'b0;
        repeat (LAT_A + 3) tick();
        checkValue("hold_pulse_count", 0, 32'(pulses.size()), 32'd3);
        for (int i = 1; i < pulses.size(); i++) begin
            checkValue("hold_spacing", 0, 32'(pulses[i] - pulses[i-1]), 32'(LAT_A + 2));
        end
        checkValue("hold_idle_cycles", 0, 32'(idle_cnt), 32'd3);

        $display("[TB] reset during WAIT of a write");
        req[0] = 1'b1; wen[0] = 1'b0; be[0] = 4'hF; addr[0] = 32'h20; di[0] = 32'hCAFEF00D;
        tick();
        req[0] = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkValue("abort_busy",  0, 32'(busy[0]),  32'h0);
        checkValue("abort_ready", 0, 32'(ready[0]), 32'h0);
        checkValue("abort_do",    0, dout[0],       32'h0);
        rdy_cnt = 0;
        repeat (LAT_A + 3) begin
            tick();
            if (ready[0] === 1'b1) rdy_cnt++;
        end
        checkValue("abort_no_ready", 0, 32'(rdy_cnt), 32'h0);
        applyStimulus(0, 1'b1, 4'h0, 32'h20, 32'h0, lat, dval, eflag);
        checkValue("abort_prior_value", 0, dval, ALIGN_CHK ? 32'hA5A5BBCC : 32'h1111BBCC);

        $display("[TB] reset and request on the same edge");
        rst = 1'b1; req[0] = 1'b1; wen[0] = 1'b1; addr[0] = 32'h10;
        tick();
        rst = 1'b0; req[0] = 1'b0;
        checkValue("collide_busy", 0, 32'(busy[0]), 32'h0);
        rdy_cnt = 0;
        repeat (LAT_A + 2) begin
            tick();
            if (ready[0] === 1'b1 || busy[0] === 1'b1) rdy_cnt++;
        end
        checkValue("collide_no_access", 0, 32'(rdy_cnt), 32'h0);

        $display("[TB] randomized traffic against the reference model");
        for (int i = 0; i < 8; i++) begin
            for (int k = 0; k < 2; k++) begin
                applyStimulus(k, 1'b0, 4'hF, 32'(i) << 2, $urandom, lat, dval, eflag);
            end
        end
        for (int c = 0; c < 1500; c++) begin
            rst = ($urandom_range(0, 59) == 0);
            for (int k = 0; k < 2; k++) begin
                req[k]  = 1'($urandom_range(0, 1));
                wen[k]  = 1'($urandom_range(0, 1));
                be[k]   = 4'($urandom);
                addr[k] = ($urandom & 32'hFFFF_F000) | (32'($urandom_range(0, 7)) << 2)
                          | (($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : 32'h0);
                di[k]   = $urandom;
            end
            tick();
        end
        rst = 1'b0;
        req[0] = 1'b0;
        req[1] = 1'b0;
        repeat (LAT_A + 3) tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
